// File: rtl/hci_package.sv
// rtl/hci_package.sv - shared constants and types for the HCI memory bank responder
package hci_package;

  localparam int unsigned DEFAULT_AW = 32;

  // x^16 + x^14 + x^13 + x^11 + 1, left-shifting Fibonacci form
  localparam int unsigned         LFSR_W    = 16;
  localparam logic [LFSR_W-1:0]   LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic       en;
    logic [3:0] thr;
  } resp_stall_cfg_t;

  // A zero seed would lock the LFSR, so it is replaced by 1
  function automatic logic [LFSR_W-1:0] stall_seed_for(input logic [LFSR_W-1:0] base,
                                                       input int unsigned bank);
    logic [LFSR_W-1:0] s;
    s = base + LFSR_W'(bank);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

endpackage

// File: rtl/hci_mem_intf.sv
// rtl/hci_mem_intf.sv - minimal HCI memory port bundle
interface hci_mem_intf #(
  parameter int unsigned AW = hci_package::DEFAULT_AW,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = DW / 8
) ();

  logic          req;
  logic          gnt;
  logic [AW-1:0] add;
  logic          wen;
  logic [BW-1:0] be;
  logic [DW-1:0] data;
  logic [DW-1:0] r_data;

  modport master (output req, add, wen, be, data, input gnt, r_data);
  modport slave  (input req, add, wen, be, data, output gnt, r_data);

endinterface

// File: rtl/hci_mem_bank_responder_bank.sv
// rtl/hci_mem_bank_responder_bank.sv - one bank: word storage, stall LFSR, grant and read register
module hci_mem_bank_responder_bank
  import hci_package::*;
#(
  parameter int unsigned       AW        = DEFAULT_AW,
  parameter int unsigned       DEPTH_LOG = 8,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  resp_stall_cfg_t stall_cfg_i,
  input  logic            req_i,
  input  logic [AW-1:0]   add_i,
  input  logic            wen_i,
  input  logic [3:0]      be_i,
  input  logic [31:0]     data_i,
  output logic            gnt_o,
  output logic [31:0]     r_data_o,
  output logic            rvalid_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;

  logic [31:0]          mem_q [DEPTH];
  logic [31:0]          mem_d [DEPTH];
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
  logic [31:0]          r_data_q, r_data_d;
  logic                 rvalid_q, rvalid_d;
  logic [DEPTH_LOG-1:0] idx;
  logic                 stall;
  logic                 unused_add;

  assign idx        = add_i[DEPTH_LOG+1:2];
  assign unused_add = ^{add_i[AW-1:DEPTH_LOG+2], add_i[1:0]};
  assign stall      = stall_cfg_i.en && (lfsr_q[3:0] < stall_cfg_i.thr);
  assign gnt_o      = req_i && !stall;

  always_comb begin
    mem_d    = mem_q;
    lfsr_d   = lfsr_q;
    r_data_d = r_data_q;
    rvalid_d = 1'b0;
    if (stall_cfg_i.en) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
    if (gnt_o && !wen_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem_d[idx][8*k +: 8] = data_i[8*k +: 8];
      end
    end
    if (gnt_o && wen_i) begin
      r_data_d = mem_q[idx];
      rvalid_d = 1'b1;
    end
    // Clear wins over a same-cycle read response; storage is left intact
    if (clear_i) begin
      lfsr_d   = SEED;
      r_data_d = '0;
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      lfsr_q   <= SEED;
      r_data_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      lfsr_q   <= lfsr_d;
      r_data_q <= r_data_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign r_data_o = r_data_q;
  assign rvalid_o = rvalid_q;

  a_req_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_i |-> !$isunknown({add_i, wen_i, be_i, data_i}));
  a_gnt_needs_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    gnt_o |-> req_i);

endmodule

// File: rtl/hci_mem_bank_responder.sv
// rtl/hci_mem_bank_responder.sv - NB_BANKS word-interleaved flop memory banks with optional grant throttling
module hci_mem_bank_responder
  import hci_package::*;
#(
  parameter int unsigned       NB_BANKS   = 8,
  parameter int unsigned       DWH        = 32,
  parameter int unsigned       AWH        = DEFAULT_AW,
  parameter int unsigned       BWH        = 4,
  parameter int unsigned       DEPTH_LOG  = 8,
  parameter logic [LFSR_W-1:0] STALL_SEED = 16'hACE1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                stall_en_i,
  input  logic [3:0]          stall_thr_i,
  hci_mem_intf.slave          in [NB_BANKS-1:0],
  output logic [NB_BANKS-1:0] rvalid_o
);

  resp_stall_cfg_t stall_cfg;

  assign stall_cfg = '{en: stall_en_i, thr: stall_thr_i};

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    hci_mem_bank_responder_bank #(
      .AW        (AWH),
      .DEPTH_LOG (DEPTH_LOG),
      .SEED      (stall_seed_for(STALL_SEED, b))
    ) u_bank (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .stall_cfg_i (stall_cfg),
      .req_i       (in[b].req),
      .add_i       (in[b].add),
      .wen_i       (in[b].wen),
      .be_i        (in[b].be),
      .data_i      (in[b].data),
      .gnt_o       (in[b].gnt),
      .r_data_o    (in[b].r_data),
      .rvalid_o    (rvalid_o[b])
    );
  end

  a_width_legal: assert property (@(posedge clk_i) (DWH == 32) && (BWH == DWH / 8))
    else $fatal(1, "hci_mem_bank_responder supports only DWH=32, BWH=4");

endmodule
